dbgu_uart_rx: RTL
=================

// Module: dbgu_uart_rx
// PURPOSE
//  Host-facing UART receive front end that feeds the dbgu32 debug unit's command parser.
//  - Deserialises 8N1 frames from the host rx line.
//  - Buffers received bytes in a DEPTH-entry FIFO and presents them on a valid/ready pop port.
//  - Drives cts for host flow control: cts=1 means hold off, cts=0 means clear to send.
// PARAMETERS
//  CLK_FREQ    12000000  system clock in Hz
//  UART_FREQ   115200    baud rate; DIV = CLK_FREQ/UART_FREQ (integer, truncated), HALF = DIV/2
//  DEPTH       16        FIFO entries; power of 2, >= 4
//  CTS_MARGIN  2         cts is raised when level >= DEPTH-CTS_MARGIN; range 1..DEPTH-1
// PORTS
//  clk        in   1               system clock; all logic on rising edge
//  reset      in   1               synchronous, active-high reset
//  rx         in   1               asynchronous serial input, idle high
//  cts        out  1               1 = host must stop sending, 0 = clear to send
//  rd_data    out  8               FIFO head byte; valid while rd_valid=1
//  rd_valid   out  1               FIFO not empty
//  rd_ready   in   1               consumer pops the head when rd_valid&rd_ready
//  level      out  $clog2(DEPTH)+1 FIFO occupancy, 0..DEPTH
//  frame_err  out  1               1-cycle pulse: stop bit sampled low
//  overrun    out  1               1-cycle pulse: byte dropped because the FIFO was full
// BEHAVIOUR
//  Reset values:
//  - cts=0, rd_valid=0, level=0, frame_err=0, overrun=0, rd_data=don't-care.
//  - FIFO pointers are cleared; the 2-FF rx synchroniser (rx_s) resets to 1; FSM enters HUNT.
//  Synchroniser: rx passes through a 2-FF synchroniser; all sampling uses rx_s (2-cycle input latency).
//  Bit counter cnt counts down and is reloaded on each state entry.
//  FSM:
//  - HUNT: count consecutive cycles with rx_s=1; after DIV such cycles go to IDLE. Any rx_s=0 restarts the count.
//    This guarantees no start bit is detected mid-frame after reset.
//  - IDLE: on rx_s=0, set cnt=HALF-1 and go to START.
//  - START: at cnt=0, resample. If rx_s=0, set cnt=DIV-1, bit=0 and go to DATA. If rx_s=1 it was a glitch: go to IDLE with no flags.
//  - DATA: at cnt=0, shift rx_s in LSB-first and reload cnt=DIV-1. After the 8th bit go to STOP.
//  - STOP: at cnt=0:
//    - rx_s=1: push the byte, return to IDLE.
//    - rx_s=0: pulse frame_err, drop the byte, go to HUNT.
//    Return happens at mid-stop-bit, so back-to-back frames are accepted.
//  FIFO (first-word fall-through):
//  - rd_data/rd_valid reflect the head combinationally from registered state.
//  - pop = rd_valid & rd_ready.
//  - push is accepted if level<DEPTH or pop occurs in the same cycle.
//  - Simultaneous push+pop leaves level unchanged, even when full.
//  - Push when full with no pop: byte dropped, overrun pulses, FIFO contents unchanged.
//  - Pop when empty: impossible, because rd_valid=0.
//  - Pointers wrap modulo DEPTH; level is an explicit counter (DEPTH distinguishes full from empty).
//  Latency: a pushed byte appears on rd_valid/rd_data the cycle after the STOP sample.
//  cts: registered as cts <= (level_next >= DEPTH-CTS_MARGIN), so it changes in the same cycle as level.
//  - Host tolerance: CTS_MARGIN bytes in flight after cts rises are still stored.
//  Reset mid-frame: the frame is discarded, no flags fire, the FIFO is cleared, and HUNT waits for an idle line.
// TESTING
//  1 Host sends 0x05 (DIV=104) -> 1 cycle after the STOP sample: rd_valid=1, rd_data=0x05, level=1, cts=0.
//    Pop -> rd_valid=0, level=0.
//  2 rd_ready=0, send 14 bytes 0x00..0x0D (DEPTH=16, MARGIN=2) -> cts=1 with level=14.
//    Pop one -> level=13, cts=0 the next cycle.
//  3 rd_ready=0, send 17 bytes 0x10..0x20 -> level=16, one overrun pulse, 0x20 lost; pops return 0x10..0x1F in order.
//    Separately, with the FIFO full, hold rd_ready=1 across the next STOP -> no overrun, level stays 16.
//  4 Frame 0xA5 with the stop bit driven 0 -> one frame_err pulse, level unchanged, FSM in HUNT.
//    A following valid 0x3C is received after one idle bit time.
//  5 rx pulsed low for DIV/4 cycles -> no push, no flags, FSM returns to IDLE.
//    An immediately following 0x55 is received correctly.
//  6 Assert reset for 1 cycle during data bit 3 of 0x00 (rx low) -> FIFO empty, no spurious byte, no flags.
//    The next 0x81 after line idle is received as 0x81.

Source files
------------

// File: rtl/dbgu_uart_rx.sv
// 8N1 UART receiver for the dbgu32 host link: 2-FF synchroniser, oversampling FSM,
// first-word fall-through byte FIFO with cts flow control and error pulses.
module dbgu_uart_rx #(
    parameter int CLK_FREQ   = 12000000,
    parameter int UART_FREQ  = 115200,
    parameter int DEPTH      = 16,
    parameter int CTS_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx,
    output logic                       cts,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int DIV  = CLK_FREQ / UART_FREQ;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;

    localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_CTS  = LW'(DEPTH - CTS_MARGIN);

    typedef enum logic [2:0] {HUNT, IDLE, START, DATA, STOP} state_t;

    state_t         state, state_next;
    logic           rx_m, rx_s;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_val;
    logic           cnt_load, cnt_zero;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           bit_clr, shift_en, push, ferr_c;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level_next;
    logic           pop, full, wr_en, ovr_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= HUNT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT:  if (rx_s && cnt_zero) state_next = IDLE;
            IDLE:  if (!rx_s) state_next = START;
            START: if (cnt_zero) state_next = rx_s ? IDLE : DATA;
            DATA:  if (cnt_zero && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (cnt_zero) state_next = rx_s ? IDLE : HUNT;
            default: state_next = HUNT;
        endcase
    end

    // HUNT reloads on every low sample so it only exits after DIV consecutive highs.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = CNT_BIT;
        bit_clr  = 1'b0;
        shift_en = 1'b0;
        push     = 1'b0;
        ferr_c   = 1'b0;
        case (state)
            HUNT: if (!rx_s) cnt_load = 1'b1;
            IDLE: if (!rx_s) begin
                cnt_load = 1'b1;
                cnt_val  = CNT_HALF;
            end
            START: if (cnt_zero && !rx_s) begin
                cnt_load = 1'b1;
                bit_clr  = 1'b1;
            end
            DATA: if (cnt_zero) begin
                cnt_load = 1'b1;
                shift_en = 1'b1;
            end
            STOP: if (cnt_zero) begin
                if (rx_s) begin
                    push = 1'b1;
                end else begin
                    ferr_c   = 1'b1;
                    cnt_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= CNT_BIT;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (cnt_load)      cnt <= cnt_val;
            else if (!cnt_zero) cnt <= cnt - CW'(1);
            if (bit_clr)       bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 3'd1;
            if (shift_en)      shreg <= {rx_s, shreg[7:1]};
        end
    end

    assign rd_valid   = (level != '0);
    assign rd_data    = mem[rd_ptr];
    assign pop        = rd_valid & rd_ready;
    assign full       = (level == LVL_FULL);
    assign wr_en      = push & (~full | pop);
    assign ovr_c      = push & full & ~pop;
    assign level_next = level + LW'(wr_en) - LW'(pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            cts       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            level     <= level_next;
            cts       <= (level_next >= LVL_CTS);
            frame_err <= ferr_c;
            overrun   <= ovr_c;
        end
    end

endmodule
